// File: rtl/clock_pulse_pkg.sv
// Shared definitions for the clock pulse stretcher: FSM state encoding and
// the timer width helper.
package clock_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Timer width must hold the larger of HOLD_CYCLES-1 and GAP_CYCLES-1, never less than one bit.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int w;
    w = 1;
    if ($clog2(hold_cycles) > w) w = $clog2(hold_cycles);
    if ($clog2(gap_cycles) > w) w = $clog2(gap_cycles);
    return w;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag; used as the HOLD/GAP window timer.
// Load has priority over count; the count rests at zero.
module load_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load a new window length or count down toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= value;
    else if (en && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length level windows, with a
// minimum low gap between windows. Pulses arriving while busy are queued in a
// saturating pending counter; a dropped pulse sets a sticky overflow flag.
// Optional macro PULSE_STRETCH_RETRIGGER_EN: a pulse during HOLD restarts the
// hold timer instead of queueing another window.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no window active, waiting for p_in
// HOLD  | level_out high, timer counts HOLD_CYCLES
// GAP   | level_out low, timer counts GAP_CYCLES before next window
module pulse_stretcher
  import clock_pulse_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_in,
  input  logic              ovf_clr,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state, state_n;
  logic              load;
  logic [CNT_W-1:0]  load_val;
  logic [CNT_W-1:0]  cnt;
  logic              zero;
  logic [PEND_W-1:0] pending_n;
  logic              ovf_set;
  logic              hold_end, gap_exit, enq, deq;

  load_down_counter #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .en    (state != IDLE),
    .cnt   (cnt),
    .zero  (zero)
  );

  // Next-state, timer load and pending-queue decisions.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_val  = HOLD_LD;
    pending_n = pending;
    ovf_set   = 1'b0;
    hold_end  = 1'b0;
    gap_exit  = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;

    case (state)
      IDLE: begin
        if (p_in) begin
          state_n = HOLD;
          load    = 1'b1;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (p_in)
          load = 1'b1;
        else if (zero)
          hold_end = 1'b1;
`else
        if (zero)
          hold_end = 1'b1;
        else if (p_in)
          enq = 1'b1;
`endif
      end
      GAP: begin
        if (zero)
          gap_exit = 1'b1;
        else if (p_in)
          enq = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // With no gap configured, the end of HOLD is itself the gap-exit point.
    if (hold_end) begin
      if (GAP_CYCLES == 0) begin
        gap_exit = 1'b1;
      end else begin
        state_n  = GAP;
        load     = 1'b1;
        load_val = GAP_LD;
        enq      = p_in;
      end
    end

    // A queued event is served first; a same-cycle pulse then takes its queue slot.
    if (gap_exit) begin
      deq = (pending != '0);
      if (deq || p_in) begin
        state_n  = HOLD;
        load     = 1'b1;
        load_val = HOLD_LD;
      end else begin
        state_n = IDLE;
      end
      if (deq && !p_in)
        pending_n = pending - PEND_W'(1);
    end else if (enq) begin
      if (pending == PEND_MAX)
        ovf_set = 1'b1;
      else
        pending_n = pending + PEND_W'(1);
    end
  end

  // State, queue and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      overflow  <= 1'b0;
      level_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      level_out <= (state_n == HOLD);
      busy      <= (state_n != IDLE);
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher (HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2).
// Each scenario pushes its hand-computed per-cycle expectations into a
// scoreboard queue; a negedge monitor pops and compares them as the cycles
// occur. Honours PULSE_STRETCH_RETRIGGER_EN to select the expected behaviour.
module tb_pulse_stretcher;

  logic       clk;
  logic       rst_n;
  logic       p_in;
  logic       ovf_clr;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  typedef struct {
    int         t;
    logic       lvl;
    logic       bsy;
    logic [1:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   t_now;
  int   n_checks;
  int   n_fail;

  pulse_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .PEND_W      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_in      (p_in),
    .ovf_clr   (ovf_clr),
    .level_out (level_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int t, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endfunction

  // Monitor: compare DUT outputs against the scoreboard entry for this cycle.
  always @(negedge clk) begin
    if (t_now >= 0 && sb.size() > 0) begin
      if (sb[0].t == t_now) begin
        exp_t e;
        e = sb.pop_front();
        chk("level_out", t_now, int'(level_out), int'(e.lvl));
        chk("busy",      t_now, int'(busy),      int'(e.bsy));
        chk("pending",   t_now, int'(pending),   int'(e.pend));
        chk("overflow",  t_now, int'(overflow),  int'(e.ovf));
      end else if (sb[0].t < t_now) begin
        void'(sb.pop_front());
        chk("missed_entry", t_now, 1, 0);
      end
    end
  end

  task automatic exp_range(input int t0, input int t1, input logic l, input logic b,
                           input logic [1:0] p, input logic o);
    for (int t = t0; t <= t1; t++) begin
      exp_t e;
      e.t = t; e.lvl = l; e.bsy = b; e.pend = p; e.ovf = o;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    p_in    = 1'b0;
    ovf_clr = 1'b0;
    t_now   = -1;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive p_in/ovf_clr from bit masks; ends inside the last cycle, before its negedge.
  task automatic run(input logic [63:0] pm, input logic [63:0] cm, input int len);
    for (int t = 0; t < len; t++) begin
      @(posedge clk);
      t_now = t;
      #1;
      p_in    = pm[t];
      ovf_clr = cm[t];
    end
  endtask

  task automatic finish_scn(input string name);
    #5;
    t_now   = -1;
    p_in    = 1'b0;
    ovf_clr = 1'b0;
    if (sb.size() != 0) begin
      chk({name, "_leftover"}, -1, sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pm, cm;
    n_checks = 0;
    n_fail   = 0;
    t_now    = -1;
    p_in     = 1'b0;
    ovf_clr  = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("reset_level",   0, int'(level_out), 0);
    chk("reset_busy",    0, int'(busy),      0);
    chk("reset_pending", 0, int'(pending),   0);
    chk("reset_ovf",     0, int'(overflow),  0);

    // Single pulse
    do_reset();
    pm = '0; cm = '0; pm[10] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 14, 1, 1, 0, 0);
    exp_range(15, 16, 0, 1, 0, 0);
    exp_range(17, 24, 0, 0, 0, 0);
    run(pm, cm, 25);
    finish_scn("single");

`ifdef PULSE_STRETCH_RETRIGGER_EN
    // Retrigger: pulses at 10 and 13 make one extended window
    do_reset();
    pm = '0; cm = '0; pm[10] = 1'b1; pm[13] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 17, 1, 1, 0, 0);
    exp_range(18, 19, 0, 1, 0, 0);
    exp_range(20, 24, 0, 0, 0, 0);
    run(pm, cm, 25);
    finish_scn("retrigger");
`else
    // Pulses at 10 and 13 give two windows
    do_reset();
    pm = '0; cm = '0; pm[10] = 1'b1; pm[13] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 13, 1, 1, 0, 0);
    exp_range(14, 14, 1, 1, 1, 0);
    exp_range(15, 16, 0, 1, 1, 0);
    exp_range(17, 20, 1, 1, 0, 0);
    exp_range(21, 22, 0, 1, 0, 0);
    exp_range(23, 27, 0, 0, 0, 0);
    run(pm, cm, 28);
    finish_scn("two_windows");

    // Pulses at 10,11,12 -> three windows
    do_reset();
    pm = '0; cm = '0; pm[10] = 1'b1; pm[11] = 1'b1; pm[12] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 11, 1, 1, 0, 0);
    exp_range(12, 12, 1, 1, 1, 0);
    exp_range(13, 14, 1, 1, 2, 0);
    exp_range(15, 16, 0, 1, 2, 0);
    exp_range(17, 20, 1, 1, 1, 0);
    exp_range(21, 22, 0, 1, 1, 0);
    exp_range(23, 26, 1, 1, 0, 0);
    exp_range(27, 28, 0, 1, 0, 0);
    exp_range(29, 31, 0, 0, 0, 0);
    run(pm, cm, 32);
    finish_scn("queue3");

    // Saturation: pulses 10..14, ovf_clr at 14 (set wins) and at 20 (clears)
    do_reset();
    pm = '0; cm = '0;
    for (int i = 10; i <= 14; i++) pm[i] = 1'b1;
    cm[14] = 1'b1; cm[20] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 11, 1, 1, 0, 0);
    exp_range(12, 12, 1, 1, 1, 0);
    exp_range(13, 13, 1, 1, 2, 0);
    exp_range(14, 14, 1, 1, 3, 0);
    exp_range(15, 16, 0, 1, 3, 1);
    exp_range(17, 20, 1, 1, 2, 1);
    exp_range(21, 22, 0, 1, 2, 0);
    exp_range(23, 26, 1, 1, 1, 0);
    exp_range(27, 28, 0, 1, 1, 0);
    exp_range(29, 32, 1, 1, 0, 0);
    exp_range(33, 34, 0, 1, 0, 0);
    exp_range(35, 37, 0, 0, 0, 0);
    run(pm, cm, 38);
    finish_scn("saturate");

    // Async reset mid-HOLD with pending=2
    do_reset();
    pm = '0; cm = '0; pm[10] = 1'b1; pm[11] = 1'b1; pm[12] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 11, 1, 1, 0, 0);
    exp_range(12, 12, 1, 1, 1, 0);
    run(pm, cm, 14);
    chk("pre_reset_pending", 13, int'(pending), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_level",   13, int'(level_out), 0);
    chk("midrst_busy",    13, int'(busy),      0);
    chk("midrst_pending", 13, int'(pending),   0);
    finish_scn("midreset_a");
    p_in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    pm = '0;
    exp_range(0, 19, 0, 0, 0, 0);
    run(pm, cm, 20);
    finish_scn("midreset_b");

    // GAP exit with pending=1 and a same-cycle pulse
    do_reset();
    pm = '0; cm = '0; pm[10] = 1'b1; pm[11] = 1'b1; pm[16] = 1'b1;
    exp_range(0, 10, 0, 0, 0, 0);
    exp_range(11, 11, 1, 1, 0, 0);
    exp_range(12, 14, 1, 1, 1, 0);
    exp_range(15, 16, 0, 1, 1, 0);
    exp_range(17, 20, 1, 1, 1, 0);
    exp_range(21, 22, 0, 1, 1, 0);
    exp_range(23, 26, 1, 1, 0, 0);
    exp_range(27, 28, 0, 1, 0, 0);
    exp_range(29, 31, 0, 0, 0, 0);
    run(pm, cm, 32);
    finish_scn("gap_exit_pulse");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
